// File: rtl/rf_dump_uart.sv
// rf_dump_uart: walks every register-file address through one read port and
// streams each word MSB-byte-first over a UART 8N1 transmit line.
module rf_dump_uart #(
  parameter int unsigned A_WIDTH      = 5,
  parameter int unsigned D_WIDTH      = 32,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [A_WIDTH-1:0] rd_addr,
  input  logic [D_WIDTH-1:0] rd_data,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam int unsigned NBYTES = D_WIDTH / 8;
  localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0]  BYTE_LAST = BYTE_W'(NBYTES - 1);
  localparam logic [A_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [BAUD_W-1:0]   r_baud;
  logic [2:0]          r_bit;
  logic [BYTE_W-1:0]   r_byte_cnt;
  logic [A_WIDTH-1:0]  r_rd_addr;
  logic [D_WIDTH-1:0]  r_shift;
  logic                r_tx;
  logic                r_busy;
  logic                r_done;
  logic                w_tx;
  logic                w_baud_last;
  logic [7:0]          w_byte;

  assign w_baud_last = (r_baud == BAUD_LAST);
  // The byte on the wire is always the top byte of the shift word.
  assign w_byte      = r_shift[D_WIDTH-1 -: 8];

  assign rd_addr = r_rd_addr;
  assign tx      = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and line-level decode; a start seen while done is still
  // showing belongs to the DONE cycle and is dropped.
  always_comb begin
    w_next = r_state;
    w_tx   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start && !r_done) w_next = S_ADDR;
      end
      S_ADDR: w_next = S_LOAD;
      S_LOAD: w_next = S_START;
      S_START: begin
        w_tx = 1'b0;
        if (w_baud_last) w_next = S_DATA;
      end
      S_DATA: begin
        w_tx = w_byte[r_bit];
        if (w_baud_last && (r_bit == 3'd7)) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_baud_last) begin
          if (r_byte_cnt != BYTE_LAST) begin
            w_next = S_START;
          end else if (r_rd_addr != ADDR_LAST) begin
            w_next = S_ADDR;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Baud, bit and byte counters plus the captured word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else begin
      if ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP)) begin
        r_baud <= w_baud_last ? '0 : r_baud + BAUD_W'(1);
      end else begin
        r_baud <= '0;
      end

      if (r_state == S_DATA) begin
        if (w_baud_last) r_bit <= r_bit + 3'd1;
      end else begin
        r_bit <= '0;
      end

      if (r_state == S_LOAD) begin
        r_shift    <= rd_data;
        r_byte_cnt <= '0;
      end else if ((r_state == S_STOP) && (w_next == S_START)) begin
        r_shift    <= r_shift << 8;
        r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
      end
    end
  end

  // Read address: cleared on accept and on leaving DONE, bumped per register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr <= '0;
    end else if ((r_state == S_IDLE) && (w_next == S_ADDR)) begin
      r_rd_addr <= '0;
    end else if ((r_state == S_STOP) && (w_next == S_ADDR)) begin
      r_rd_addr <= r_rd_addr + A_WIDTH'(1);
    end else if (r_state == S_DONE) begin
      r_rd_addr <= '0;
    end
  end

  // Registered line and status; busy covers the visible done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tx   <= w_tx;
      r_busy <= (w_next != S_IDLE) || (r_state == S_DONE);
      r_done <= (r_state == S_DONE);
    end
  end

endmodule
